// File: rtl/fdct_8x8_serial.sv
// fdct_8x8_serial: serial-in 8x8 forward DCT, row pass then column pass.
// Ports: clk, rst_n, in_data/in_valid/in_ready pixels, out_coef/out_valid/out_ready block.
module fdct_8x8_serial #(
  parameter int WIN   = 9,
  parameter int WOUT  = 12,
  parameter int CFRAC = 12,
  parameter int RFRAC = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [WIN-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [64*WOUT-1:0]     out_coef,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int RSH = CFRAC - RFRAC;
  localparam int CSH = CFRAC + RFRAC;
  localparam logic signed [31:0] RRND = 32'sd1 <<< (RSH - 1);
  localparam logic signed [31:0] CRND = 32'sd1 <<< (CSH - 1);
  localparam logic signed [31:0] CMAX = (32'sd1 <<< (WOUT - 1)) - 32'sd1;
  localparam logic signed [31:0] CMIN = -(32'sd1 <<< (WOUT - 1));

  // Cosine ROM: angle (2n+1)k in units of pi/16 folded into one
  // quadrant picks the magnitude; quadrants 2 and 3 are negative.
  function automatic logic signed [31:0] f_cos(
    input logic [2:0] k,
    input logic [2:0] n
  );
    logic [4:0]  a;
    logic [3:0]  m;
    logic [3:0]  j;
    logic [31:0] mag;
    a = 5'({n, 1'b1}) * 5'(k);
    m = a[3:0];
    j = (m > 4'd8) ? 4'd0 - m : m;
    case (j)
      4'd0, 4'd4: mag = 32'd1448;
      4'd1:       mag = 32'd2009;
      4'd2:       mag = 32'd1892;
      4'd3:       mag = 32'd1703;
      4'd5:       mag = 32'd1138;
      4'd6:       mag = 32'd784;
      4'd7:       mag = 32'd400;
      default:    mag = 32'd0;
    endcase
    f_cos = (a > 5'd8 && a < 5'd24) ? -$signed(mag) : $signed(mag);
  endfunction

  logic [1:0]               r_state;
  logic [5:0]               r_cnt;
  logic signed [WIN-1:0]    r_xbuf [64];
  logic signed [15:0]       r_rbuf [64];
  logic [64*WOUT-1:0]       r_coef;

  logic signed [31:0]       w_opa [8];
  logic signed [31:0]       w_opc [8];
  logic signed [31:0]       w_acc;
  logic signed [31:0]       w_rsh;
  logic signed [31:0]       w_csh;
  logic signed [15:0]       w_row;
  logic signed [WOUT-1:0]   w_col;
  logic [5:0]               w_slot;

  // Eight multipliers shared by both passes. The low counter bits
  // always select the output frequency; the high bits pick the row
  // (row pass) or the column (column pass) of the source buffer.
  always_comb begin
    w_acc = '0;
    for (int n = 0; n < 8; n++) begin
      if (r_state == S_COL)
        w_opa[n] = 32'(r_rbuf[{3'(n), r_cnt[5:3]}]);
      else
        w_opa[n] = 32'(r_xbuf[{r_cnt[5:3], 3'(n)}]);
      w_opc[n] = f_cos(r_cnt[2:0], 3'(n));
      w_acc = w_acc + w_opa[n] * w_opc[n];
    end
  end

  always_comb begin
    w_rsh = (w_acc + RRND) >>> RSH;
    w_csh = (w_acc + CRND) >>> CSH;
    if (w_rsh > 32'sd32767)       w_row = 16'sh7fff;
    else if (w_rsh < -32'sd32768) w_row = 16'sh8000;
    else                          w_row = w_rsh[15:0];
    if (w_csh > CMAX)      w_col = CMAX[WOUT-1:0];
    else if (w_csh < CMIN) w_col = CMIN[WOUT-1:0];
    else                   w_col = w_csh[WOUT-1:0];
  end

  // column pass counter is {k,u}; output slot is 8*u+k
  assign w_slot = {r_cnt[2:0], r_cnt[5:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_coef  <= '0;
      for (int i = 0; i < 64; i++) begin
        r_xbuf[i] <= '0;
        r_rbuf[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_xbuf[r_cnt] <= in_data;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd63) r_state <= S_ROW;
          end
        end
        S_ROW: begin
          r_rbuf[r_cnt] <= w_row;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_COL;
        end
        S_COL: begin
          r_coef[w_slot*WOUT +: WOUT] <= w_col;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DONE);
  assign out_coef  = r_coef;

endmodule

// File: tb/tb_fdct_8x8_serial.sv
// tb_fdct_8x8_serial: directed and model-based checks of fdct_8x8_serial.
// Drives pixel blocks, checks latency, coefficients, handshakes and reset.
module tb_fdct_8x8_serial;
  localparam int WIN  = 9;
  localparam int WOUT = 12;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic signed [WIN-1:0] in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [64*WOUT-1:0]    out_coef;
  logic                  out_valid;
  logic                  out_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int px [64];
  int expv [64];
  int cm [8][8];
  real PI = 3.14159265358979;

  fdct_8x8_serial dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_coef(out_coef), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coef(input int k);
    logic signed [WOUT-1:0] t;
    t = out_coef[k*WOUT +: WOUT];
    return int'(t);
  endfunction

  task automatic init_cos;
    real r;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        r = (k == 0 ? 1.0 / $sqrt(2.0) : 1.0) * 2048.0
            * $cos((2 * n + 1) * k * PI / 16.0);
        cm[k][n] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end
  endtask

  task automatic model;
    longint acc;
    longint rr [64];
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++)
          acc += longint'(cm[k][n]) * px[8*r+n];
        rr[8*r+k] = (acc + 256) >>> 9;
      end
    for (int u = 0; u < 8; u++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int r = 0; r < 8; r++)
          acc += longint'(cm[u][r]) * rr[8*r+k];
        acc = (acc + 16384) >>> 15;
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        expv[8*u+k] = int'(acc);
      end
  endtask

  task automatic idct_err(output real maxe);
    real s, cu, cv, e;
    maxe = 0.0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        s = 0.0;
        for (int u = 0; u < 8; u++)
          for (int v = 0; v < 8; v++) begin
            cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            s += cu * cv / 4.0 * coef(8*u+v)
                 * $cos((2*x+1)*u*PI/16.0) * $cos((2*y+1)*v*PI/16.0);
          end
        e = s - px[8*x+y];
        if (e < 0.0) e = -e;
        if (e > maxe) maxe = e;
      end
  endtask

  task automatic wait_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input bit gaps, output int s0,
                            output int s63, output bit rdy_ok);
    rdy_ok = 1'b1;
    s0 = 0;
    s63 = 0;
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        wait_cycle;
      end
      in_valid = 1'b1;
      in_data = WIN'(px[i]);
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      wait_cycle;
      if (i == 0) s0 = cyc;
      if (i == 63) s63 = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      wait_cycle;
      lat++;
    end
  endtask

  task automatic release_block;
    out_ready = 1'b1;
    wait_cycle;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      wait_cycle;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready c=%0d got=%b want=1", c, in_ready);
      end
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_out_valid c=%0d got=%b want=0", c, out_valid);
      end
      total++;
      if (out_coef !== '0) begin
        bad++;
        $display("FAIL reset_out_coef c=%0d got=%h want=0", c, out_coef);
      end
    end
    rst_n = 1'b1;
    wait_cycle;
  endtask

  task automatic test_flat;
    int s0, s63, lat, want;
    bit ok;
    foreach (px[i]) px[i] = 100;
    send_block(1'b0, s0, s63, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL flat_in_ready got=%b want=1", ok);
    end
    wait_out(lat);
    total++;
    if (lat !== 128) begin
      bad++;
      $display("FAIL flat_latency got=%0d want=128", lat);
    end
    for (int k = 0; k < 64; k++) begin
      want = (k == 0) ? 800 : 0;
      total++;
      if (coef(k) !== want) begin
        bad++;
        $display("FAIL flat_coef k=%0d got=%0d want=%0d", k, coef(k), want);
      end
    end
    in_valid = 1'b1;
    in_data = 9'sd7;
    for (int c = 0; c < 10; c++) begin
      wait_cycle;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL flat_hold c=%0d got=%b%b want=10", c,
                 out_valid, in_ready);
      end
      total++;
      if (coef(0) !== 800 || out_coef[64*WOUT-1:WOUT] !== '0) begin
        bad++;
        $display("FAIL flat_hold_coef c=%0d got=%0d want=800", c, coef(0));
      end
    end
    in_valid = 1'b0;
    release_block;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flat_release got=%b%b want=01", out_valid, in_ready);
    end
    total++;
    if (coef(0) !== 800) begin
      bad++;
      $display("FAIL flat_keep got=%0d want=800", coef(0));
    end
  endtask

  task automatic test_extreme;
    int s0, s63, lat, want;
    bit ok;
    for (int b = 0; b < 2; b++) begin
      foreach (px[i]) px[i] = (b == 0) ? -256 : 0;
      send_block(1'b0, s0, s63, ok);
      wait_out(lat);
      total++;
      if (lat !== 128) begin
        bad++;
        $display("FAIL extreme_latency b=%0d got=%0d want=128", b, lat);
      end
      for (int k = 0; k < 64; k++) begin
        want = (k == 0 && b == 0) ? -2048 : 0;
        total++;
        if (coef(k) !== want) begin
          bad++;
          $display("FAIL extreme_coef b=%0d k=%0d got=%0d want=%0d",
                   b, k, coef(k), want);
        end
      end
      release_block;
    end
  endtask

  task automatic test_random;
    int s0, s63, lat;
    bit ok;
    real maxe;
    for (int b = 0; b < 3; b++) begin
      foreach (px[i]) px[i] = int'($urandom_range(0, 511)) - 256;
      model;
      out_ready = (b == 1);
      send_block(1'b1, s0, s63, ok);
      total++;
      if (ok !== 1'b1) begin
        bad++;
        $display("FAIL rand_in_ready b=%0d got=%b want=1", b, ok);
      end
      wait_out(lat);
      total++;
      if (lat !== 128) begin
        bad++;
        $display("FAIL rand_latency b=%0d got=%0d want=128", b, lat);
      end
      for (int k = 0; k < 64; k++) begin
        total++;
        if (coef(k) !== expv[k]) begin
          bad++;
          $display("FAIL rand_coef b=%0d k=%0d got=%0d want=%0d",
                   b, k, coef(k), expv[k]);
        end
      end
      idct_err(maxe);
      total++;
      if (maxe > 2.0) begin
        bad++;
        $display("FAIL rand_roundtrip b=%0d got=%f want<=2", b, maxe);
      end
      release_block;
    end
  endtask

  task automatic test_reset_mid;
    int s0, s63, lat, want;
    bit ok;
    foreach (px[i]) px[i] = int'($urandom_range(0, 511)) - 256;
    send_block(1'b0, s0, s63, ok);
    repeat (30) wait_cycle;
    rst_n = 1'b0;
    wait_cycle;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_coef !== '0) begin
      bad++;
      $display("FAIL midreset_state got=%b%b want=10", in_ready, out_valid);
    end
    rst_n = 1'b1;
    wait_cycle;
    foreach (px[i]) px[i] = 100;
    send_block(1'b0, s0, s63, ok);
    wait_out(lat);
    total++;
    if (lat !== 128) begin
      bad++;
      $display("FAIL midreset_latency got=%0d want=128", lat);
    end
    for (int k = 0; k < 64; k++) begin
      want = (k == 0) ? 800 : 0;
      total++;
      if (coef(k) !== want) begin
        bad++;
        $display("FAIL midreset_coef k=%0d got=%0d want=%0d",
                 k, coef(k), want);
      end
    end
    release_block;
  endtask

  task automatic test_back_to_back;
    int s0a, s0b, s63, lat;
    bit ok;
    for (int b = 0; b < 2; b++) begin
      foreach (px[i]) px[i] = int'($urandom_range(0, 511)) - 256;
      model;
      if (b == 0) send_block(1'b0, s0a, s63, ok);
      else        send_block(1'b0, s0b, s63, ok);
      total++;
      if (ok !== 1'b1) begin
        bad++;
        $display("FAIL b2b_in_ready b=%0d got=%b want=1", b, ok);
      end
      wait_out(lat);
      total++;
      if (lat !== 128) begin
        bad++;
        $display("FAIL b2b_latency b=%0d got=%0d want=128", b, lat);
      end
      for (int k = 0; k < 64; k++) begin
        total++;
        if (coef(k) !== expv[k]) begin
          bad++;
          $display("FAIL b2b_coef b=%0d k=%0d got=%0d want=%0d",
                   b, k, coef(k), expv[k]);
        end
      end
      release_block;
    end
    total++;
    if (s0b - s0a !== 193) begin
      bad++;
      $display("FAIL b2b_period got=%0d want=193", s0b - s0a);
    end
  endtask

  initial begin
    init_cos;
    test_reset;
    test_flat;
    test_extreme;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
